// File: rtl/lcd_bus_receiver_if.sv
// 8080-style 8-bit parallel LCD write bus as seen at the receiver pins.
// The master modport belongs to whatever drives the panel bus; the slave
// modport is the receiver side, which only ever listens.
interface lcd_bus_receiver_if;
  logic [7:0] lcd_db;
  logic       lcd_wr;
  logic       lcd_d_c;
  logic       lcd_rd;
  logic       lcd_reset;

  modport master (
    output lcd_db,
    output lcd_wr,
    output lcd_d_c,
    output lcd_rd,
    output lcd_reset
  );

  modport slave (
    input lcd_db,
    input lcd_wr,
    input lcd_d_c,
    input lcd_rd,
    input lcd_reset
  );
endinterface

// File: rtl/lcd_bus_receiver.sv
// Receiver/decoder for the 8080-style LCD write bus. Decodes the ILI9341
// CASET / PASET / RAMWR subset and emits one pixel-write event (x, y,
// RGB565) per pixel written, so the LCD path can be mirrored or checked
// inside the bus-source clock domain.
module lcd_bus_receiver #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_receiver_if.slave bus,
  output logic              pix_valid,
  output logic [8:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic [15:0]       pix_rgb,
  output logic              frame_start,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              win_err,
  output logic              rd_err
);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Default window corners and the panel limits used by the validity check.
  // Limits are one bit wider so that WIDTH/HEIGHT up to 512 compare cleanly.
  localparam logic [8:0] EC_DEFAULT = 9'(WIDTH - 1);
  localparam logic [8:0] EP_DEFAULT = 9'(HEIGHT - 1);
  localparam logic [9:0] WIDTH_LIM  = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_LIM = 10'(HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } state_t;

  typedef enum logic {
    PH_HI,
    PH_LO
  } phase_t;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [7:0]             db_sync [SYNC_STAGES];

  logic       wr_s;
  logic       dc_s;
  logic       rd_s;
  logic       rst_s;
  logic [7:0] db_s;

  // Shift every bus pin through the same number of flops so data, d_c and
  // the strobe arrive aligned; idle levels are loaded on reset so leaving
  // reset can never look like a strobe edge or a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sync  <= '1;
      dc_sync  <= '0;
      rd_sync  <= '1;
      rst_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        db_sync[i] <= '0;
      end
    end else begin
      wr_sync    <= {wr_sync[SYNC_STAGES-2:0], bus.lcd_wr};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], bus.lcd_d_c};
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], bus.lcd_rd};
      rst_sync   <= {rst_sync[SYNC_STAGES-2:0], bus.lcd_reset};
      db_sync[0] <= bus.lcd_db;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        db_sync[i] <= db_sync[i-1];
      end
    end
  end

  assign wr_s  = wr_sync[SYNC_STAGES-1];
  assign dc_s  = dc_sync[SYNC_STAGES-1];
  assign rd_s  = rd_sync[SYNC_STAGES-1];
  assign rst_s = rst_sync[SYNC_STAGES-1];
  assign db_s  = db_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Write-event detection
  // ---------------------------------------------------------------------
  logic       wr_prev;
  logic       ev_q;
  logic       ev_dc;
  logic [7:0] ev_db;

  // Register the rising edge of the synchronised strobe together with the
  // byte and d_c from the same stage, giving the decoder a clean one-cycle
  // event with its payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b1;
      ev_q    <= 1'b0;
      ev_dc   <= 1'b0;
      ev_db   <= '0;
    end else begin
      wr_prev <= wr_s;
      ev_q    <= wr_s & ~wr_prev;
      ev_dc   <= dc_s;
      ev_db   <= db_s;
    end
  end

  // ---------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------
  state_t     state,    state_n;
  phase_t     phase,    phase_n;
  logic [1:0] par_idx,  par_idx_n;
  logic [8:0] sh_start, sh_start_n;
  logic       sh_end8,  sh_end8_n;
  logic [8:0] sc, sc_n, ec, ec_n, sp, sp_n, ep, ep_n;
  logic [8:0] cur_x,    cur_x_n;
  logic [8:0] cur_y,    cur_y_n;
  logic [7:0] hi_byte,  hi_byte_n;

  logic        pix_valid_n;
  logic [8:0]  pix_x_n;
  logic [8:0]  pix_y_n;
  logic [15:0] pix_rgb_n;
  logic        frame_start_n;
  logic        cmd_valid_n;
  logic [7:0]  cmd_byte_n;
  logic        win_err_n;
  logic        rd_err_n;

  logic soft_rst;
  logic win_ok;

  assign soft_rst = ~rst_s;
  assign win_ok   = (sc <= ec) && (sp <= ep) &&
                    ({1'b0, ec} < WIDTH_LIM) && ({1'b0, ep} < HEIGHT_LIM);

  // Next-state and output decode: panel reset wins over any coincident
  // event, commands always restart the decoder, data bytes are interpreted
  // according to the command currently in force.
  always_comb begin
    state_n       = state;
    phase_n       = phase;
    par_idx_n     = par_idx;
    sh_start_n    = sh_start;
    sh_end8_n     = sh_end8;
    sc_n          = sc;
    ec_n          = ec;
    sp_n          = sp;
    ep_n          = ep;
    cur_x_n       = cur_x;
    cur_y_n       = cur_y;
    hi_byte_n     = hi_byte;
    pix_valid_n   = 1'b0;
    pix_x_n       = pix_x;
    pix_y_n       = pix_y;
    pix_rgb_n     = pix_rgb;
    frame_start_n = 1'b0;
    cmd_valid_n   = 1'b0;
    cmd_byte_n    = cmd_byte;
    win_err_n     = win_err;
    rd_err_n      = rd_err | ~rd_s;

    if (soft_rst) begin
      state_n    = ST_IDLE;
      phase_n    = PH_HI;
      par_idx_n  = '0;
      sh_start_n = '0;
      sh_end8_n  = 1'b0;
      sc_n       = '0;
      ec_n       = EC_DEFAULT;
      sp_n       = '0;
      ep_n       = EP_DEFAULT;
      cur_x_n    = '0;
      cur_y_n    = '0;
      hi_byte_n  = '0;
      pix_x_n    = '0;
      pix_y_n    = '0;
      pix_rgb_n  = '0;
      cmd_byte_n = '0;
    end else if (ev_q) begin
      if (!ev_dc) begin
        cmd_valid_n = 1'b1;
        cmd_byte_n  = ev_db;
        phase_n     = PH_HI;
        par_idx_n   = '0;
        case (ev_db)
          CMD_CASET: state_n = ST_CASET;
          CMD_PASET: state_n = ST_PASET;
          CMD_RAMWR: begin
            state_n       = ST_RAMWR;
            cur_x_n       = sc;
            cur_y_n       = sp;
            frame_start_n = 1'b1;
          end
          default:   state_n = ST_IGNORE;
        endcase
      end else begin
        case (state)
          ST_CASET, ST_PASET: begin
            case (par_idx)
              2'd0:    sh_start_n[8]   = ev_db[0];
              2'd1:    sh_start_n[7:0] = ev_db;
              2'd2:    sh_end8_n       = ev_db[0];
              default: begin
                if (state == ST_CASET) begin
                  sc_n = sh_start;
                  ec_n = {sh_end8, ev_db};
                end else begin
                  sp_n = sh_start;
                  ep_n = {sh_end8, ev_db};
                end
                state_n = ST_IGNORE;
              end
            endcase
            par_idx_n = par_idx + 2'd1;
          end
          ST_RAMWR: begin
            if (phase == PH_HI) begin
              hi_byte_n = ev_db;
              phase_n   = PH_LO;
            end else begin
              phase_n = PH_HI;
              if (win_ok) begin
                pix_valid_n = 1'b1;
                pix_x_n     = cur_x;
                pix_y_n     = cur_y;
                pix_rgb_n   = {hi_byte, ev_db};
                if (cur_x == ec) begin
                  cur_x_n = sc;
                  cur_y_n = (cur_y == ep) ? sp : cur_y + 9'd1;
                end else begin
                  cur_x_n = cur_x + 9'd1;
                end
              end else begin
                win_err_n = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers; the sticky error flags only clear here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= PH_HI;
      par_idx     <= '0;
      sh_start    <= '0;
      sh_end8     <= 1'b0;
      sc          <= '0;
      ec          <= EC_DEFAULT;
      sp          <= '0;
      ep          <= EP_DEFAULT;
      cur_x       <= '0;
      cur_y       <= '0;
      hi_byte     <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      win_err     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      par_idx     <= par_idx_n;
      sh_start    <= sh_start_n;
      sh_end8     <= sh_end8_n;
      sc          <= sc_n;
      ec          <= ec_n;
      sp          <= sp_n;
      ep          <= ep_n;
      cur_x       <= cur_x_n;
      cur_y       <= cur_y_n;
      hi_byte     <= hi_byte_n;
      pix_valid   <= pix_valid_n;
      pix_x       <= pix_x_n;
      pix_y       <= pix_y_n;
      pix_rgb     <= pix_rgb_n;
      frame_start <= frame_start_n;
      cmd_valid   <= cmd_valid_n;
      cmd_byte    <= cmd_byte_n;
      win_err     <= win_err_n;
      rd_err      <= rd_err_n;
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed sequences followed by
// randomized command/data traffic, compared against a window/pixel-index
// reference model.
module tb_lcd_bus_receiver;

  localparam int SYNC = 3;
  localparam int W    = 320;
  localparam int H    = 240;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_rgb;
  logic        frame_start;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        win_err;
  logic        rd_err;

  lcd_bus_receiver_if bus ();

  lcd_bus_receiver #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_start(frame_start),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .win_err    (win_err),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: window corners, parameter bytes collected so far, a
  // pending high byte and a pixel index k counted from RAMWR entry.
  int m_sc, m_ec, m_sp, m_ep;
  int m_mode;
  int m_params[$];
  int m_hi;
  int m_k;
  int m_last_x, m_last_y, m_last_rgb, m_last_cmd;
  int m_werr, m_rerr;
  int m_fs, m_cmds;
  logic [33:0] exp_q[$];

  int fs_seen  = 0;
  int cmd_seen = 0;

  function automatic void modelPanelReset();
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
    m_mode = 0;
    m_params.delete();
    m_hi = -1;
    m_k = 0;
    m_last_x = 0; m_last_y = 0; m_last_rgb = 0; m_last_cmd = 0;
  endfunction

  function automatic void modelCmd(input int b);
    m_cmds++;
    m_last_cmd = b;
    m_params.delete();
    m_hi = -1;
    if (b == 'h2A) m_mode = 1;
    else if (b == 'h2B) m_mode = 2;
    else if (b == 'h2C) begin
      m_mode = 3;
      m_k = 0;
      m_fs++;
    end else m_mode = 4;
  endfunction

  function automatic void modelData(input int b);
    int s, e, w, h, x, y, rgb;
    if (m_mode == 1 || m_mode == 2) begin
      m_params.push_back(b);
      if (m_params.size() == 4) begin
        s = ((m_params[0] & 1) << 8) | m_params[1];
        e = ((m_params[2] & 1) << 8) | m_params[3];
        if (m_mode == 1) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
        m_mode = 4;
      end
    end else if (m_mode == 3) begin
      if (m_hi < 0) m_hi = b;
      else begin
        if (m_sc <= m_ec && m_sp <= m_ep && m_ec < W && m_ep < H) begin
          w = m_ec - m_sc + 1;
          h = m_ep - m_sp + 1;
          x = m_sc + (m_k % w);
          y = m_sp + ((m_k / w) % h);
          rgb = (m_hi << 8) | b;
          exp_q.push_back({9'(y), 9'(x), 16'(rgb)});
          m_last_x = x; m_last_y = y; m_last_rgb = rgb;
          m_k++;
        end else begin
          m_werr = 1;
        end
        m_hi = -1;
      end
    end
  endfunction

  // Drive one bus write with randomized low/high widths of 2..4 clocks.
  task automatic applyStimulus(input logic dc, input int b);
    if (dc) modelData(b); else modelCmd(b);
    @(negedge clk);
    bus.lcd_d_c = dc;
    bus.lcd_db  = 8'(b);
    bus.lcd_wr  = 1'b0;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    @(negedge clk);
    bus.lcd_wr = 1'b1;
    repeat ($urandom_range(2, 4)) @(posedge clk);
  endtask

  task automatic sendPixel(input int rgb);
    applyStimulus(1'b1, (rgb >> 8) & 'hFF);
    applyStimulus(1'b1, rgb & 'hFF);
  endtask

  task automatic sendWindow(input int cmd, input int s, input int e);
    applyStimulus(1'b0, cmd);
    applyStimulus(1'b1, ((s >> 8) & 1) | ($urandom & 'hFE));
    applyStimulus(1'b1, s & 'hFF);
    applyStimulus(1'b1, ((e >> 8) & 1) | ($urandom & 'hFE));
    applyStimulus(1'b1, e & 'hFF);
  endtask

  task automatic checkpoint(input string tag);
    repeat (SYNC + 8) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "/pending_pix"}, 64'(exp_q.size()), 64'd0);
    checkOutput({tag, "/cmd_byte"}, 64'(cmd_byte), 64'(m_last_cmd));
    checkOutput({tag, "/win_err"}, 64'(win_err), 64'(m_werr));
    checkOutput({tag, "/rd_err"}, 64'(rd_err), 64'(m_rerr));
    checkOutput({tag, "/frame_starts"}, 64'(fs_seen), 64'(m_fs));
    checkOutput({tag, "/cmds"}, 64'(cmd_seen), 64'(m_cmds));
    checkOutput({tag, "/last_pix"}, {30'd0, pix_y, pix_x, pix_rgb},
                {30'd0, 9'(m_last_y), 9'(m_last_x), 16'(m_last_rgb)});
  endtask

  task automatic hardReset();
    @(negedge clk);
    reset = 1'b1;
    modelPanelReset();
    m_werr = 0;
    m_rerr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/outputs",
                {pix_valid, frame_start, cmd_valid, cmd_byte, win_err, rd_err, pix_x, pix_y, pix_rgb},
                64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic panelReset();
    repeat (SYNC + 8) @(posedge clk);
    @(negedge clk);
    bus.lcd_reset = 1'b0;
    modelPanelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.lcd_reset = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
  endtask

  task automatic rdPulse();
    @(negedge clk);
    bus.lcd_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.lcd_rd = 1'b1;
    m_rerr = 1;
  endtask

  // Monitor: every pixel pulse is matched against the model queue in order.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_seen++;
      checkOutput("frame_start_with_cmd", 64'(cmd_valid), 64'd1);
    end
    if (cmd_valid) cmd_seen++;
    if (pix_valid) begin
      if (cmd_valid) checkOutput("pix_cmd_overlap", 64'd1, 64'd0);
      if (exp_q.size() == 0) checkOutput("pix_unexpected", {30'd0, pix_y, pix_x, pix_rgb}, 64'd0);
      else checkOutput("pix_xy_rgb", {30'd0, pix_y, pix_x, pix_rgb}, {30'd0, exp_q.pop_front()});
    end
  end

  // Watchdog so a stuck run still reports and ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, hi, lo, act, s, e, cnt;
    bus.lcd_db    = 8'h00;
    bus.lcd_wr    = 1'b1;
    bus.lcd_d_c   = 1'b0;
    bus.lcd_rd    = 1'b1;
    bus.lcd_reset = 1'b1;
    m_fs = 0;
    m_cmds = 0;
    hardReset();
    checkpoint("reset");

    $display("[TB] basic RAMWR");
    applyStimulus(1'b0, 'h2C);
    sendPixel('hF800);
    sendPixel('h07E0);
    checkpoint("basic");

    $display("[TB] windowed write with wrap");
    sendWindow('h2A, 10, 12);
    sendWindow('h2B, 5, 6);
    applyStimulus(1'b0, 'h2C);
    for (int i = 0; i < 7; i++) sendPixel(('h1100 * i + 'h0042) & 'hFFFF);
    checkpoint("wrap");

    $display("[TB] incomplete CASET");
    hardReset();
    applyStimulus(1'b0, 'h2A);
    applyStimulus(1'b1, 'h00);
    applyStimulus(1'b1, 'h30);
    applyStimulus(1'b0, 'h2C);
    sendPixel('hBEEF);
    checkpoint("partial_caset");

    $display("[TB] odd byte dropped by command");
    applyStimulus(1'b0, 'h2C);
    applyStimulus(1'b1, 'hAB);
    applyStimulus(1'b0, 'h00);
    applyStimulus(1'b0, 'h2C);
    sendPixel('h1234);
    checkpoint("odd_byte");

    $display("[TB] invalid window then panel reset");
    sendWindow('h2A, 20, 10);
    applyStimulus(1'b0, 'h2C);
    sendPixel('h5555);
    checkpoint("invalid_win");
    panelReset();
    applyStimulus(1'b0, 'h2C);
    sendPixel('h6666);
    checkpoint("after_panel_reset");

    $display("[TB] latency and lcd_rd");
    applyStimulus(1'b0, 'h2C);
    applyStimulus(1'b1, 'hC3);
    repeat (SYNC + 8) @(posedge clk);
    @(negedge clk);
    bus.lcd_d_c = 1'b1;
    bus.lcd_db  = 8'h5A;
    bus.lcd_wr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.lcd_wr = 1'b1;
    modelData('h5A);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pix_valid) break;
    end
    checkOutput("latency", 64'(n), 64'(SYNC + 2));
    checkpoint("latency");
    rdPulse();
    checkpoint("rd_err");

    $display("[TB] randomized traffic");
    hardReset();
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 9);
      if (act <= 2 || act == 3) begin
        s = $urandom_range(0, W - 1);
        e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : s + $urandom_range(0, 3);
        if ($urandom_range(0, 5) == 0) begin
          applyStimulus(1'b0, 'h2A);
          cnt = $urandom_range(0, 3);
          for (int j = 0; j < cnt; j++) applyStimulus(1'b1, $urandom_range(0, 255));
        end else begin
          sendWindow((act == 3) ? 'h2B : 'h2A, s, e);
        end
      end else if (act == 4) begin
        s = $urandom_range(0, H - 1);
        e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : s + $urandom_range(0, 2);
        sendWindow('h2B, s, e);
      end else if (act <= 7) begin
        applyStimulus(1'b0, 'h2C);
        cnt = $urandom_range(0, 8);
        for (int j = 0; j < cnt; j++) begin
          hi = $urandom_range(0, 255);
          lo = $urandom_range(0, 255);
          sendPixel((hi << 8) | lo);
        end
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, $urandom_range(0, 255));
      end else if (act == 8) begin
        applyStimulus(1'b0, $urandom_range(0, 255));
        applyStimulus(1'b1, $urandom_range(0, 255));
      end else begin
        if ($urandom_range(0, 1) == 0) panelReset();
        else rdPulse();
      end
      if (it % 8 == 7) checkpoint("random");
    end
    checkpoint("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receiver/decoder for the 8080-style 8-bit parallel LCD write bus: lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset.
- Decodes the ILI9341 command subset used by the screen controller: CASET 0x2A, PASET 0x2B, RAMWR 0x2C. Emits one pixel-write event per pixel, carrying screen coordinates and RGB565 colour.
- Used as a synthesizable mirror/checker of the LCD path, e.g. feeding a capture framebuffer or comparing against the VGA pixel stream. Runs in the bus-source clock domain (clk_100).

Parameters:
- WIDTH, 320, panel column count; default window end column = WIDTH-1.
- HEIGHT, 240, panel row count; default window end row = HEIGHT-1.
- SYNC_STAGES, 2, flop stages on all bus inputs (2..4).

Ports:
- clk  in  1  receiver clock
- reset  in  1  synchronous, active-high reset
- lcd_db  in  8  bus data
- lcd_wr  in  1  write strobe, active low; data latched on rising edge
- lcd_d_c  in  1  0 = command byte, 1 = data byte
- lcd_rd  in  1  read strobe, active low; unsupported
- lcd_reset  in  1  panel reset, active low
- pix_valid  out  1  one-cycle pixel-write pulse
- pix_x  out  9  column of the pixel
- pix_y  out  9  row of the pixel
- pix_rgb  out  16  RGB565 colour, high byte first on the bus
- frame_start  out  1  one-cycle pulse when a RAMWR command is accepted
- cmd_valid  out  1  one-cycle pulse for every command byte
- cmd_byte  out  8  last command byte
- win_err  out  1  sticky: pixel dropped because the window is invalid
- rd_err  out  1  sticky: lcd_rd low was sampled

Behaviour:
- Input synchronisation
  - All five bus inputs pass through SYNC_STAGES flops.
  - A write event is a 0->1 transition of the synchronised lcd_wr. lcd_db and lcd_d_c are taken from the same synchronised stage.
  - The bus guarantees lcd_wr low ≥2 clk and high ≥2 clk. Narrower pulses are undefined.
- Reset
  - reset=1, or synchronised lcd_reset=0, sets state IDLE and default window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1.
  - Current position resets to (0,0).
  - All outputs go to 0, including win_err and rd_err (reset only; lcd_reset does not clear the sticky flags).
  - Either reset mid-sequence discards any partial parameter or pixel byte.
- Command bytes (d_c=0)
  - Pulse cmd_valid and update cmd_byte. These are registered one cycle after the write event.
  - Every command aborts the current state and drops any held odd pixel byte.
  - Next state: 0x2A -> CASET (param index 0); 0x2B -> PASET (index 0); 0x2C -> RAMWR; any other value -> IGNORE.
- State CASET
  - Data bytes in order: SC[15:8], SC[7:0], EC[15:8], EC[7:0]. Only bits [8:0] are kept.
  - Bytes are latched into shadow registers.
  - On the 4th byte, SC/EC are committed and the state becomes IGNORE. Further data is ignored.
  - An incomplete sequence commits nothing.
- State PASET: identical to CASET, for SP/EP.
- State RAMWR
  - Entry:
    - Position is set to (SC,SP) and the byte phase to HI.
    - frame_start pulses together with cmd_valid.
  - HI data byte: stored.
  - LO data byte:
    - Forms pix_rgb = {hi,lo} and outputs the current (x,y).
    - pix_valid pulses 1 cycle after the LO write event, i.e. SYNC_STAGES+2 clk after lcd_wr rises at the pin.
  - Address advance after each pixel:
    - x==EC: x=SC and y increments; if y==EP, then y=SP (wrap to window top-left).
    - Otherwise x increments.
  - Invalid window:
    - The window is invalid if SC>EC, SP>EP, EC≥WIDTH or EP≥HEIGHT.
    - While invalid, pix_valid is suppressed, win_err is set, and the position does not advance.
- IDLE/IGNORE: data bytes are discarded.
- lcd_rd
  - Sampled low -> rd_err is set.
  - No bus drive (the port is input only) and no state change.
- Simultaneity: a write event coinciding with reset is discarded. pix_valid and cmd_valid are never high in the same cycle.

Test Plan:
- Reset, then cmd 0x2C + data 0xF8,0x00,0x07,0xE0 -> frame_start pulses once; pix_valid at (0,0) rgb=0xF800, then at (1,0) rgb=0x07E0.
- CASET 0,10,0,12; PASET 0,5,0,6; RAMWR + 7 pixels -> coordinates in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), then (10,5) again (wrap).
- CASET with only 2 params, then RAMWR + 1 pixel -> window unchanged; pixel lands at (0,0).
- RAMWR, HI byte 0xAB, then cmd 0x00, then RAMWR + 0x12,0x34 -> single pix_valid with rgb=0x1234 at (0,0); 0xAB is lost.
- CASET 0,20,0,10, then RAMWR + 1 pixel -> no pix_valid; win_err=1. Then lcd_reset low for 3 clk, then RAMWR + 1 pixel -> pix_valid at (0,0); win_err still 1.
- Measure latency with SYNC_STAGES=3 -> pix_valid exactly 5 clk after lcd_wr rises on the LO byte. lcd_rd low for 2 clk -> rd_err=1 and no other output changes.
